wav_sel_xfade: RTL and testbench

//  Parametrised waveform selector for the synth voice path: picks one of NUM_WAV oscillator

---
 rtl/wav_sel_xfade.sv | 146 ++++++++++++++
 tb/tb_wav_sel_xfade.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/wav_sel_xfade.sv
// Waveform selector: debounced next/prev buttons pick one of NUM_WAV oscillator
// samples; a change of selection is crossfaded linearly over 2**XF_LOG2 samples.
module wav_sel_xfade #(
  parameter int WIDTH   = 8,
  parameter int NUM_WAV = 4,
  parameter int DEB_CYC = 16,
  parameter int XF_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_en,
  input  logic [NUM_WAV*WIDTH-1:0]   wav_bus,
  input  logic                       btn_next,
  input  logic                       btn_prev,
  output logic [WIDTH-1:0]           wav_out,
  output logic [$clog2(NUM_WAV)-1:0] sel,
  output logic                       busy
);

  localparam int SEL_W = $clog2(NUM_WAV);
  localparam int CNT_W = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);
  localparam int AW    = WIDTH + XF_LOG2 + 1;
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_WAV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);
  localparam logic [AW-1:0]    N_W     = AW'(1) << XF_LOG2;

  typedef enum logic {IDLE, FADE} state_t;

  logic [WIDTH-1:0] wav_arr [NUM_WAV];
  logic [1:0]       btn_raw;
  logic [1:0]       press;

  assign btn_raw = {btn_prev, btn_next};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WAV; gi++) begin : g_unpack
      assign wav_arr[gi] = wav_bus[gi*WIDTH +: WIDTH];
    end

    // Index 0 is next, index 1 is prev.
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic [1:0]       sync_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             level_reg;
      logic             level_d_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_reg    <= '0;
          cnt_reg     <= '0;
          level_reg   <= 1'b0;
          level_d_reg <= 1'b0;
        end else begin
          sync_reg    <= {sync_reg[0], btn_raw[gi]};
          level_d_reg <= level_reg;
          // Any cycle where the synced input agrees with the level restarts the count.
          if (sync_reg[1] != level_reg) begin
            if (cnt_reg == CNT_MAX) begin
              level_reg <= sync_reg[1];
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign press[gi] = level_reg & ~level_d_reg;
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic [SEL_W-1:0]   old_sel_reg, old_sel_next;
  logic [XF_LOG2-1:0] k_reg, k_next;
  logic               busy_reg, busy_next;
  logic [WIDTH-1:0]   wav_out_reg, wav_out_next;

  logic [AW-1:0]      step;
  logic [AW-1:0]      mix_sum;
  logic [SEL_W-1:0]   sel_inc, sel_dec;

  assign step    = AW'(k_reg) + AW'(1);
  assign mix_sum = AW'(wav_arr[old_sel_reg]) * (N_W - step) + AW'(wav_arr[sel_reg]) * step;
  assign sel_inc = (sel_reg == SEL_MAX) ? '0 : sel_reg + 1'b1;
  assign sel_dec = (sel_reg == '0) ? SEL_MAX : sel_reg - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      sel_reg     <= '0;
      old_sel_reg <= '0;
      k_reg       <= '0;
      busy_reg    <= 1'b0;
      wav_out_reg <= '0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      old_sel_reg <= old_sel_next;
      k_reg       <= k_next;
      busy_reg    <= busy_next;
      wav_out_reg <= wav_out_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    old_sel_next = old_sel_reg;
    k_next       = k_reg;
    busy_next    = busy_reg;
    wav_out_next = wav_out_reg;
    case (state_reg)
      IDLE: begin
        // A strobe coinciding with acceptance still plays the old selection.
        if (sample_en) wav_out_next = wav_arr[sel_reg];
        if (press[0] ^ press[1]) begin
          old_sel_next = sel_reg;
          sel_next     = press[0] ? sel_inc : sel_dec;
          k_next       = '0;
          busy_next    = 1'b1;
          state_next   = FADE;
        end
      end
      FADE: begin
        if (sample_en) begin
          k_next       = k_reg + 1'b1;
          wav_out_next = mix_sum[XF_LOG2 +: WIDTH];
          if (k_reg == '1) begin
            busy_next  = 1'b0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wav_out = wav_out_reg;
  assign sel     = sel_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_wav_sel_xfade.sv
// Directed bench for wav_sel_xfade: expected samples are queued when strobes are
// issued and popped when the registered output is observed.
module tb_wav_sel_xfade;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic [31:0] wav_bus = 32'hFFC0_8000;
  logic        btn_next = 1'b0;
  logic        btn_prev = 1'b0;
  logic [7:0]  wav_out;
  logic [1:0]  sel;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  wav_sel_xfade #(.WIDTH(8), .NUM_WAV(4), .DEB_CYC(4), .XF_LOG2(2)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .wav_bus(wav_bus),
    .btn_next(btn_next), .btn_prev(btn_prev),
    .wav_out(wav_out), .sel(sel), .busy(busy)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobe; the queued expectation is popped once the edge has updated wav_out.
  task automatic strobe(input string tag);
    logic [7:0] e;
    sample_en = 1'b1;
    tick(1);
    sample_en = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check(tag, {24'd0, wav_out}, {24'd0, e});
    $display("strobe %s: wav_out=%02h sel=%0d busy=%0b", tag, wav_out, sel, busy);
  endtask

  task automatic press(input logic nxt, input logic prv);
    btn_next = nxt;
    btn_prev = prv;
    tick(12);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick(12);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    // 1: reset state and first strobe
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_wav", {24'd0, wav_out}, 32'h00);
    check("rst_sel", {30'd0, sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h00);
    strobe("t1");

    // 2: next press, fade 00 -> 80
    press(1'b1, 1'b0);
    check("t2_sel", {30'd0, sel}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back(8'h20); exp_q.push_back(8'h40);
    exp_q.push_back(8'h60); exp_q.push_back(8'h80);
    for (int i = 0; i < 4; i++) strobe("t2_fade");
    check("t2_busy_end", {31'd0, busy}, 32'd0);

    // 3: bouncing button must not register
    for (int i = 0; i < 15; i++) begin
      btn_next = ~i[0];
      tick(2);
    end
    btn_next = 1'b0;
    tick(10);
    check("t3_sel", {30'd0, sel}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(8'h80);
    strobe("t3");

    // 4: prev from 0 wraps to 3, fade 00 -> FF
    do_reset();
    press(1'b0, 1'b1);
    check("t4_sel", {30'd0, sel}, 32'd3);
    exp_q.push_back(8'h3F); exp_q.push_back(8'h7F);
    exp_q.push_back(8'hBF); exp_q.push_back(8'hFF);
    for (int i = 0; i < 4; i++) strobe("t4_fade");
    check("t4_busy_end", {31'd0, busy}, 32'd0);

    // 5: simultaneous press dropped; press during fade dropped
    press(1'b1, 1'b1);
    check("t5_both_sel", {30'd0, sel}, 32'd3);
    check("t5_both_busy", {31'd0, busy}, 32'd0);
    press(1'b1, 1'b0);
    check("t5_wrap_sel", {30'd0, sel}, 32'd0);
    exp_q.push_back(8'hBF);
    strobe("t5_fade");
    press(1'b1, 1'b0);
    check("t5_busy_sel", {30'd0, sel}, 32'd0);
    check("t5_busy_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back(8'h7F); exp_q.push_back(8'h3F); exp_q.push_back(8'h00);
    for (int i = 0; i < 3; i++) strobe("t5_fade");
    check("t5_busy_end", {31'd0, busy}, 32'd0);

    // 6: async reset mid-fade
    press(1'b1, 1'b0);
    exp_q.push_back(8'h20); exp_q.push_back(8'h40);
    strobe("t6_fade");
    strobe("t6_fade");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_wav", {24'd0, wav_out}, 32'h00);
    check("t6_rst_sel", {30'd0, sel}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);
    exp_q.push_back(8'h00);
    strobe("t6_after");

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
